inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  Fetch/execute sequencer for the single-cycle core. It drives the instruction ROM
//  (address, chip-enable) and waits on a multi-cycle ROM ready handshake. It latches
//  each instruction and presents it to decode as a one-cycle execute slot; the core's
//  write-back enable is gated by inst_valid_o. It replaces free-running pc_reg
//  sequencing when the ROM has wait states, and adds stall, redirect and fetch timeout.
// PARAMETERS
//  ADDR_W    32      ROM address / PC width
//  DATA_W    32      instruction width
//  TIMEOUT   16      max FETCH cycles without rom_ready_i before error (>=2)
//  RESET_PC  'h0     PC loaded on reset (word aligned)
// PORTS
//  clk              in   1       single clock; all logic on rising edge
//  rst              in   1       synchronous reset, active-low (rst==0 resets)
//  rom_ready_i      in   1       ROM data valid this cycle (sampled only in FETCH)
//  rom_data_i       in   DATA_W  ROM read data
//  rom_ce_o         out  1       ROM chip enable
//  rom_addr_o       out  ADDR_W  ROM address = current PC
//  inst_o           out  DATA_W  latched instruction to decode
//  pc_o             out  ADDR_W  PC of inst_o
//  inst_valid_o     out  1       execute slot; gates regfile write enable
//  stall_i          in   1       hold request (debug/halt)
//  branch_flag_i    in   1       redirect request, sampled in EXEC only
//  branch_target_i  in   ADDR_W  redirect target; bits [1:0] forced to 0
//  timeout_err_o    out  1       sticky fetch-timeout error
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, pc=RESET_PC, inst_o=0 (NOP), pc_o=RESET_PC,
//   inst_valid_o=0, rom_ce_o=0, rom_addr_o=RESET_PC, timeout_err_o=0, wait_cnt=0.
//   Reset overrides all other events in any state, including mid-FETCH.
//  States: IDLE, FETCH, EXEC, HOLD, ERROR. All outputs are decoded from registers,
//   with no combinational input->output path.
//  IDLE: stall_i=1 -> HOLD; else -> FETCH.
//  FETCH: rom_ce_o=1, rom_addr_o=pc. wait_cnt increments each cycle.
//   rom_ready_i=1 -> latch inst_o<=rom_data_i, pc_o<=pc, wait_cnt<=0, -> EXEC.
//   rom_ready_i=0 and wait_cnt==TIMEOUT-1 -> timeout_err_o<=1, -> ERROR.
//   stall_i is ignored in FETCH; an outstanding fetch always completes or times out.
//  EXEC: inst_valid_o=1 for exactly this one cycle; rom_ce_o=0.
//   Next pc = branch_flag_i ? {branch_target_i[ADDR_W-1:2],2'b00} : pc+4.
//   pc+4 wraps modulo 2^ADDR_W (max-4 -> 0).
//   stall_i=1 -> HOLD; else -> FETCH. The pc update happens in both cases.
//  HOLD: rom_ce_o=0, inst_valid_o=0; inst_o/pc_o keep their last values.
//   stall_i=0 -> FETCH.
//  ERROR: rom_ce_o=0, inst_valid_o=0; the only exit is reset.
//  rom_ready_i outside FETCH is ignored. Back-to-back fetch, zero wait states:
//   FETCH,EXEC,FETCH,EXEC..., i.e. 2 cycles per instruction.
//   Latency is ROM ready cycle + 1 to inst_valid_o.
//  branch_flag_i/branch_target_i are ignored outside EXEC.
// TESTING
//  T1 reset: hold rst=0 for 3 clk with random inputs -> rom_ce_o=0, inst_valid_o=0,
//     rom_addr_o=RESET_PC, timeout_err_o=0. Release -> FETCH addr 0 next cycle.
//  T2 zero-wait stream: rom_ready_i=1 always, data=addr^'hA5A5_0000 ->
//     inst_valid_o every 2nd cycle; pc_o 0,4,8,C; inst_o matches each addr.
//  T3 wait states: ready after 3 FETCH cycles -> ce held for 3 cycles at the same addr;
//     inst_valid_o on the 4th cycle; no timeout flagged.
//  T4 redirect: branch_flag_i=1, target='h0000_0103 in EXEC of pc 8 -> next fetch addr
//     'h100; branch_flag_i=1 in FETCH -> ignored.
//  T5 stall: stall_i=1 in EXEC -> HOLD, ce=0, inst_o stable; stall_i asserted mid-FETCH
//     -> fetch completes; release -> fetch resumes at the next pc.
//  T6 timeout/wrap: no ready for 16 cycles -> timeout_err_o=1 sticky, ce=0 until rst=0.
//     RESET_PC='hFFFF_FFFC -> second fetch addr 0.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Fetch/execute sequencer: drives the instruction ROM, waits on its ready handshake,
// and presents each latched instruction to decode as a one-cycle execute slot.
module inst_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ready_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              timeout_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HOLD,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_o;
    logic [DATA_W-1:0] r_inst;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_err;
    logic [ADDR_W-1:0] w_br_tgt;
    logic              w_fetch_expire;

    assign w_br_tgt       = branch_target_i & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign w_fetch_expire = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = stall_i ? S_HOLD : S_FETCH;
            S_FETCH: begin
                if (rom_ready_i)         w_next = S_EXEC;
                else if (w_fetch_expire) w_next = S_ERROR;
            end
            S_EXEC:  w_next = stall_i ? S_HOLD : S_FETCH;
            S_HOLD:  if (!stall_i) w_next = S_FETCH;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rom_ce_o     = (r_state == S_FETCH);
        inst_valid_o = (r_state == S_EXEC);
    end

    // The wait counter only runs in FETCH, so every fetch starts its timeout from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_pc_o     <= RESET_PC;
            r_inst     <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (rom_ready_i) begin
                        r_inst     <= rom_data_i;
                        r_pc_o     <= r_pc;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        if (w_fetch_expire) r_err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_pc       <= branch_flag_i ? w_br_tgt : r_pc + ADDR_W'(4);
                    r_wait_cnt <= '0;
                end
                default: r_wait_cnt <= '0;
            endcase
        end
    end

    assign rom_addr_o    = r_pc;
    assign inst_o        = r_inst;
    assign pc_o          = r_pc_o;
    assign timeout_err_o = r_err;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: reset, zero-wait stream, wait states, redirect,
// stall, timeout, and PC wrap on a second instance with RESET_PC at the top of memory.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ready_i;
    logic [31:0] rom_data_i, rom_data2;
    logic        stall_i, branch_flag_i;
    logic [31:0] branch_target_i;

    logic        rom_ce_o, inst_valid_o, timeout_err_o;
    logic [31:0] rom_addr_o, inst_o, pc_o;
    logic        ce2, valid2, err2;
    logic [31:0] addr2, inst2, pc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM model: data is the address XORed with a fixed tag.
    assign rom_data_i = rom_addr_o ^ 32'hA5A5_0000;
    assign rom_data2  = addr2 ^ 32'hA5A5_0000;

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_ready_i(rom_ready_i), .rom_data_i(rom_data_i),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .inst_o(inst_o), .pc_o(pc_o),
        .inst_valid_o(inst_valid_o), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .timeout_err_o(timeout_err_o)
    );

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .rom_ready_i(rom_ready_i), .rom_data_i(rom_data2),
        .rom_ce_o(ce2), .rom_addr_o(addr2), .inst_o(inst2), .pc_o(pc2),
        .inst_valid_o(valid2), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .timeout_err_o(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] a2;
        rst = 1'b0; rom_ready_i = 1'b0; stall_i = 1'b0;
        branch_flag_i = 1'b0; branch_target_i = '0;

        // T1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            rom_ready_i     = 1'($urandom);
            stall_i         = 1'($urandom);
            branch_flag_i   = 1'($urandom);
            branch_target_i = $urandom;
            tick();
        end
        chk("rst_ce",    {31'b0, rom_ce_o},      32'd0);
        chk("rst_valid", {31'b0, inst_valid_o},  32'd0);
        chk("rst_addr",  rom_addr_o,             32'h0);
        chk("rst_err",   {31'b0, timeout_err_o}, 32'd0);
        chk("rst_inst",  inst_o,                 32'h0);
        chk("rst_pc",    pc_o,                   32'h0);
        chk("rst_addr2", addr2,                  32'hFFFF_FFFC);

        rst = 1'b1; rom_ready_i = 1'b1; stall_i = 1'b0;
        branch_flag_i = 1'b0; branch_target_i = '0;
        tick();

        // T2: zero-wait stream, plus PC wrap on the second instance
        for (int i = 0; i < 4; i++) begin
            a  = 32'(4 * i);
            a2 = 32'hFFFF_FFFC + 32'(4 * i);
            chk("z_ce",    {31'b0, rom_ce_o},     32'd1);
            chk("z_addr",  rom_addr_o,            a);
            chk("z_nval",  {31'b0, inst_valid_o}, 32'd0);
            chk("wrap_addr", addr2,               a2);
            tick();
            chk("z_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("z_pc",    pc_o,                  a);
            chk("z_inst",  inst_o,                a ^ 32'hA5A5_0000);
            chk("z_ce0",   {31'b0, rom_ce_o},     32'd0);
            tick();
        end

        // T3: two wait states, ready on third FETCH cycle
        rom_ready_i = 1'b0;
        chk("w_addr0", rom_addr_o, 32'h10);
        tick();
        chk("w_ce1",   {31'b0, rom_ce_o},     32'd1);
        chk("w_addr1", rom_addr_o,            32'h10);
        chk("w_nval1", {31'b0, inst_valid_o}, 32'd0);
        tick();
        chk("w_ce2",   {31'b0, rom_ce_o},     32'd1);
        chk("w_addr2", rom_addr_o,            32'h10);
        rom_ready_i = 1'b1;
        tick();
        chk("w_valid", {31'b0, inst_valid_o},  32'd1);
        chk("w_pc",    pc_o,                   32'h10);
        chk("w_inst",  inst_o,                 32'hA5A5_0010);
        chk("w_err",   {31'b0, timeout_err_o}, 32'd0);

        // T4: redirect in EXEC, ignored in FETCH
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0103;
        tick();
        chk("br_addr", rom_addr_o, 32'h100);
        branch_target_i = 32'h0000_0200;
        tick();
        chk("br_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("br_pc",    pc_o,                  32'h100);
        branch_flag_i = 1'b0;
        tick();
        chk("br_ign", rom_addr_o, 32'h104);

        // T5: stall in EXEC -> HOLD, stall in FETCH ignored
        tick();
        chk("st_valid", {31'b0, inst_valid_o}, 32'd1);
        stall_i = 1'b1;
        tick();
        chk("hold_ce",   {31'b0, rom_ce_o},     32'd0);
        chk("hold_val",  {31'b0, inst_valid_o}, 32'd0);
        chk("hold_inst", inst_o,                32'hA5A5_0104);
        tick();
        chk("hold_ce2",  {31'b0, rom_ce_o},     32'd0);
        chk("hold_pc",   pc_o,                  32'h104);
        stall_i = 1'b0; rom_ready_i = 1'b0;
        tick();
        chk("res_ce",   {31'b0, rom_ce_o}, 32'd1);
        chk("res_addr", rom_addr_o,        32'h108);
        stall_i = 1'b1;
        tick();
        chk("sf_ce",   {31'b0, rom_ce_o}, 32'd1);
        chk("sf_addr", rom_addr_o,        32'h108);
        rom_ready_i = 1'b1;
        tick();
        chk("sf_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("sf_pc",    pc_o,                  32'h108);
        stall_i = 1'b0;
        tick();
        chk("sf_next", rom_addr_o, 32'h10C);

        // T6: timeout after 16 FETCH cycles without ready
        rom_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_ce_last", {31'b0, rom_ce_o},      32'd1);
        chk("to_err_pre", {31'b0, timeout_err_o}, 32'd0);
        tick();
        chk("to_err", {31'b0, timeout_err_o}, 32'd1);
        chk("to_ce",  {31'b0, rom_ce_o},      32'd0);
        rom_ready_i = 1'b1; stall_i = 1'b1;
        tick();
        stall_i = 1'b0;
        tick();
        tick();
        chk("to_sticky", {31'b0, timeout_err_o}, 32'd1);
        chk("to_ce_hi",  {31'b0, rom_ce_o},      32'd0);
        chk("to_nval",   {31'b0, inst_valid_o},  32'd0);
        rst = 1'b0;
        tick();
        chk("to_clr",  {31'b0, timeout_err_o}, 32'd0);
        chk("to_addr", rom_addr_o,             32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
